// File: rtl/reg_dump_streamer.sv
// Streams a snapshot of the register file (header byte, then hi/lo byte of each register)
// over a valid/ready byte interface, driving the register file display read port itself.
module reg_dump_streamer #(
    parameter int           NUM_REGS = 8,
    parameter int           REG_W    = 3,
    parameter int           DATA_W   = 16,
    parameter logic [7:0]   HEADER   = 8'hA5
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              start,
    output logic [REG_W-1:0]  regDisp,
    input  logic [DATA_W-1:0] dataDisp,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE, HDR, SETTLE, CAPT, SEND_HI, SEND_LO, DONE
    } state_t;

    localparam logic [REG_W-1:0] LAST_IDX = REG_W'(NUM_REGS - 1);

    state_t           state_reg,    state_next;
    logic [REG_W-1:0] idx_reg,      idx_next;
    logic [7:0]       tx_data_reg,  tx_data_next;
    logic             tx_valid_reg, tx_valid_next;
    logic             busy_reg,     busy_next;
    logic             done_reg,     done_next;
    // Only the low byte must survive the hi-byte transfer; the hi byte goes straight to tx_data.
    logic [7:0]       shadow_reg,   shadow_next;

    logic transfer;
    assign transfer = tx_valid_reg & tx_ready;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            shadow_reg   <= 8'h00;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            shadow_reg   <= shadow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = tx_valid_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        shadow_next   = shadow_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    idx_next      = '0;
                    tx_data_next  = HEADER;
                    tx_valid_next = 1'b1;
                    busy_next     = 1'b1;
                    state_next    = HDR;
                end
            end
            HDR: begin
                if (transfer) begin
                    tx_valid_next = 1'b0;
                    state_next    = SETTLE;
                end
            end
            // Register file samples regDisp on this edge; its read data is ready in CAPT.
            SETTLE: state_next = CAPT;
            CAPT: begin
                shadow_next   = dataDisp[7:0];
                tx_data_next  = dataDisp[DATA_W-1 -: 8];
                tx_valid_next = 1'b1;
                state_next    = SEND_HI;
            end
            SEND_HI: begin
                if (transfer) begin
                    tx_data_next = shadow_reg;
                    state_next   = SEND_LO;
                end
            end
            SEND_LO: begin
                if (transfer) begin
                    tx_valid_next = 1'b0;
                    if (idx_reg == LAST_IDX) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = SETTLE;
                    end
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The frame index doubles as the display address, so regDisp holds the last index in IDLE.
    assign regDisp  = idx_reg;
    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
